// File: rtl/instr_fetch_queue_if.sv
// Bundle of fetch-side signals between the instruction fetch queue, the
// instruction memory, the redirect source and the decode stage.
interface instr_fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;
    logic        instr_ready;

    // The fetch queue itself
    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc4,
        input  imem_ready, imem_data, redirect, redirect_pc, instr_ready
    );

    // Memory, redirect source and consumer
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc4,
        output imem_ready, imem_data, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches from a fetch PC and
// buffers the returned {pc, instruction} pairs in a small FIFO for decode.
// A redirect flushes the FIFO and restarts fetching at the new word address.
// DEPTH must be a power of two between 2 and 16 so the pointers wrap for free.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                 clk_i,
    input logic                 rst_i,
    instr_fetch_queue_if.master bus
);

    localparam int unsigned    PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned    CntW    = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    logic push;
    logic pop;

    // Fetch request, head-entry outputs and the push/pop handshakes
    always_comb begin
        bus.imem_req    = (count_q < FullCnt) && !bus.redirect;
        bus.imem_addr   = fetch_pc_q;
        bus.instr_valid = (count_q != '0);
        bus.instr       = instr_mem[rd_ptr_q];
        bus.instr_pc    = pc_mem[rd_ptr_q];
        bus.instr_pc4   = pc_mem[rd_ptr_q] + 32'd4;
        push            = bus.imem_req && bus.imem_ready;
        pop             = bus.instr_valid && bus.instr_ready;
    end

    // Next-state: redirect flushes everything, otherwise push/pop bookkeeping
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (bus.redirect) begin
            // Any same-cycle pop is dropped; push cannot happen since req is low
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PtrW'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            fetch_pc_q <= {RESET_PC[31:2], 2'b00};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage, unreset; a write during reset is harmless since pointers clear
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= fetch_pc_q;
            instr_mem[wr_ptr_q] <= bus.imem_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios with literal expectations
// plus a queue-based reference model compared against the DUT every cycle.
module tb_instr_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_queue_if bus ();

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Memory always returns the word for the address presented
    assign bus.imem_data = bus.imem_addr ^ KEY;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: queue of fetched PCs, instruction derived from PC
    logic [31:0] mq[$];
    logic [31:0] mpc;
    bit          model_ok = 0;
    bit          m_push;
    bit          m_pop;

    always @(posedge clk) begin
        if (!rst) begin
            mq.delete();
            mpc      = {RESET_PC[31:2], 2'b00};
            model_ok = 1;
        end else if (model_ok) begin
            if (bus.redirect) begin
                mq.delete();
                mpc = {bus.redirect_pc[31:2], 2'b00};
            end else begin
                m_push = (mq.size() < DEPTH) && bus.imem_ready;
                m_pop  = (mq.size() != 0) && bus.instr_ready;
                if (m_pop) void'(mq.pop_front());
                if (m_push) begin
                    mq.push_back(mpc);
                    mpc = mpc + 32'd4;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (model_ok) begin
            check("imem_req", 32'(bus.imem_req), 32'((mq.size() < DEPTH) && !bus.redirect));
            check("imem_addr", bus.imem_addr, mpc);
            check("instr_valid", 32'(bus.instr_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                check("instr", bus.instr, mq[0] ^ KEY);
                check("instr_pc", bus.instr_pc, mq[0]);
                check("instr_pc4", bus.instr_pc4, mq[0] + 32'd4);
            end
        end
    end

    initial begin
        bus.imem_ready  = 1'b1;
        bus.instr_ready = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;

        // Reset outputs
        tick(2);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_req", 32'(bus.imem_req), 32'd1);
        check("rst_addr", bus.imem_addr, RESET_PC);

        // Streaming: first word visible the cycle after acceptance
        rst = 1'b1;
        tick(1);
        check("stream_valid", 32'(bus.instr_valid), 32'd1);
        check("stream_pc0", bus.instr_pc, 32'h0000_0000);
        check("stream_instr0", bus.instr, 32'hA5A5_0000);
        tick(2);
        check("stream_pc2", bus.instr_pc, 32'h0000_0008);
        check("stream_instr2", bus.instr, 32'hA5A5_0008);
        check("stream_addr", bus.imem_addr, 32'h0000_000C);

        // Backpressure: fill to DEPTH then stall requests
        rst = 1'b0;
        bus.instr_ready = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(4);
        check("full_req", 32'(bus.imem_req), 32'd0);
        check("full_addr", bus.imem_addr, 32'h0000_0010);
        check("full_head", bus.instr_pc, 32'h0000_0000);
        tick(2);
        check("full_hold_req", 32'(bus.imem_req), 32'd0);
        check("full_hold_addr", bus.imem_addr, 32'h0000_0010);
        bus.instr_ready = 1'b1;
        tick(1);
        bus.instr_ready = 1'b0;
        check("refill_req", 32'(bus.imem_req), 32'd1);
        check("refill_addr", bus.imem_addr, 32'h0000_0010);
        check("refill_head", bus.instr_pc, 32'h0000_0004);
        tick(1);
        check("refull_req", 32'(bus.imem_req), 32'd0);

        // Reset while full discards the queue
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        check("midrst_valid", 32'(bus.instr_valid), 32'd0);
        check("midrst_addr", bus.imem_addr, RESET_PC);

        // Redirect with three entries queued
        tick(3);
        check("pre_redir_valid", 32'(bus.instr_valid), 32'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        #1;
        check("redir_req", 32'(bus.imem_req), 32'd0);
        tick(1);
        bus.redirect = 1'b0;
        check("redir_valid", 32'(bus.instr_valid), 32'd0);
        check("redir_addr", bus.imem_addr, 32'h0000_0100);
        bus.instr_ready = 1'b1;
        tick(1);
        check("redir_first_pc", bus.instr_pc, 32'h0000_0100);

        // Address wrap at the top of the space
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        tick(1);
        bus.redirect = 1'b0;
        check("wrap_addr", bus.imem_addr, 32'hFFFF_FFF8);
        tick(3);
        check("wrap_head0", bus.instr_pc, 32'hFFFF_FFF8);
        bus.instr_ready = 1'b1;
        tick(1);
        check("wrap_head1", bus.instr_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", bus.instr_pc4, 32'h0000_0000);
        check("wrap_instr1", bus.instr, 32'h5A5A_FFFC);
        tick(1);
        check("wrap_head2", bus.instr_pc, 32'h0000_0000);

        // Random handshakes, checked by the per-cycle model comparison
        for (int i = 0; i < 1000; i++) begin
            bus.imem_ready  = 1'($urandom_range(0, 1));
            bus.instr_ready = 1'($urandom_range(0, 1));
            tick(1);
        end

        tick(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
